// File: rtl/move_selector.sv
// move_selector: button-driven cursor and move capture for the move engine.
// Latches source/destination squares, pulses START, then reports the result.
module move_selector (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_select,
  input  logic                  btn_cancel,
  input  logic [7:0][7:0][3:0]  board,
  input  logic                  turn,
  output logic                  START,
  output logic [2:0]            startX,
  output logic [2:0]            startY,
  output logic [2:0]            endX,
  output logic [2:0]            endY,
  output logic [2:0]            cursorX,
  output logic [2:0]            cursorY,
  output logic                  src_selected,
  output logic                  move_ok,
  output logic                  move_bad
);

  localparam int WAIT_CYCLES = 4;
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    SelSrc,
    SelDst,
    Issue,
    Wait,
    Report
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cur_x_q, cur_x_d;
  logic [2:0] cur_y_q, cur_y_d;
  logic [2:0] sx_q, sx_d;
  logic [2:0] sy_q, sy_d;
  logic [2:0] ex_q, ex_d;
  logic [2:0] ey_q, ey_d;
  logic [2:0] cnt_q, cnt_d;
  logic       tai_q, tai_d;
  logic       sel_q, sel_d;
  logic       start_q, start_d;
  logic       ok_q, ok_d;
  logic       bad_q, bad_d;

  logic [3:0] sq;
  logic       own;
  logic       on_src;
  logic       dir_en;

  // Next-state, selection capture and result decision.
  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    cnt_d   = cnt_q;
    tai_d   = tai_q;
    sel_d   = sel_q;
    start_d = 1'b0;
    ok_d    = 1'b0;
    bad_d   = 1'b0;
    dir_en  = 1'b0;
    sq      = board[cur_x_q][cur_y_q];
    own     = (sq != 4'b0000) && (sq[3] == turn);
    on_src  = (cur_x_q == sx_q) && (cur_y_q == sy_q);

    unique case (state_q)
      SelSrc: begin
        if (btn_cancel) begin
          sel_d = 1'b0;
        end else if (btn_select) begin
          if (own) begin
            sx_d    = cur_x_q;
            sy_d    = cur_y_q;
            sel_d   = 1'b1;
            state_d = SelDst;
          end
        end else begin
          dir_en = 1'b1;
        end
      end
      SelDst: begin
        if (btn_cancel) begin
          sel_d   = 1'b0;
          state_d = SelSrc;
        end else if (btn_select) begin
          if (on_src) begin
            sel_d   = 1'b0;
            state_d = SelSrc;
          end else if (own) begin
            sx_d = cur_x_q;
            sy_d = cur_y_q;
          end else begin
            ex_d    = cur_x_q;
            ey_d    = cur_y_q;
            tai_d   = turn;
            start_d = 1'b1;
            state_d = Issue;
          end
        end else begin
          dir_en = 1'b1;
        end
      end
      Issue: begin
        cnt_d   = 3'd0;
        state_d = Wait;
      end
      Wait: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == WAIT_LAST) begin
          ok_d    = (turn != tai_q);
          bad_d   = (turn == tai_q);
          sel_d   = 1'b0;
          state_d = Report;
        end
      end
      Report: begin
        state_d = SelSrc;
      end
      default: begin
        state_d = SelSrc;
      end
    endcase

    // Opposing pulses on one axis cancel naturally in mod-8 arithmetic.
    if (dir_en) begin
      cur_x_d = cur_x_q + 3'(btn_right) - 3'(btn_left);
      cur_y_d = cur_y_q + 3'(btn_down) - 3'(btn_up);
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= SelSrc;
      cur_x_q <= 3'd4;
      cur_y_q <= 3'd6;
      sx_q    <= 3'd0;
      sy_q    <= 3'd0;
      ex_q    <= 3'd0;
      ey_q    <= 3'd0;
      cnt_q   <= 3'd0;
      tai_q   <= 1'b0;
      sel_q   <= 1'b0;
      start_q <= 1'b0;
      ok_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      cnt_q   <= cnt_d;
      tai_q   <= tai_d;
      sel_q   <= sel_d;
      start_q <= start_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
    end
  end

  assign START        = start_q;
  assign startX       = sx_q;
  assign startY       = sy_q;
  assign endX         = ex_q;
  assign endY         = ey_q;
  assign cursorX      = cur_x_q;
  assign cursorY      = cur_y_q;
  assign src_selected = sel_q;
  assign move_ok      = ok_q;
  assign move_bad     = bad_q;

endmodule

// File: tb/tb_move_selector.sv
// tb_move_selector: directed and random checks of move_selector against
// an integer cursor/selection model.
module tb_move_selector;

  logic                 Clk = 1'b0;
  logic                 Reset;
  logic                 btn_up, btn_down, btn_left, btn_right;
  logic                 btn_select, btn_cancel;
  logic [7:0][7:0][3:0] board;
  logic                 turn;
  logic                 START;
  logic [2:0]           startX, startY, endX, endY;
  logic [2:0]           cursorX, cursorY;
  logic                 src_selected, move_ok, move_bad;

  move_selector dut (
    .Clk(Clk), .Reset(Reset),
    .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right),
    .btn_select(btn_select), .btn_cancel(btn_cancel),
    .board(board), .turn(turn),
    .START(START),
    .startX(startX), .startY(startY),
    .endX(endX), .endY(endY),
    .cursorX(cursorX), .cursorY(cursorY),
    .src_selected(src_selected),
    .move_ok(move_ok), .move_bad(move_bad)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;
  int mx, my, msx, msy, mex, mey;
  bit msel;
  bit exp_start;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic clr_btn;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    btn_select = 0; btn_cancel = 0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".curx"}, 8'(cursorX), 8'(mx));
    chk({tag, ".cury"}, 8'(cursorY), 8'(my));
    chk({tag, ".sel"}, 8'(src_selected), 8'(msel));
    chk({tag, ".sx"}, 8'(startX), 8'(msx));
    chk({tag, ".sy"}, 8'(startY), 8'(msy));
    chk({tag, ".start"}, 8'(START), 8'(exp_start));
    chk({tag, ".ok"}, 8'(move_ok), 8'd0);
    chk({tag, ".bad"}, 8'(move_bad), 8'd0);
    if (exp_start) begin
      chk({tag, ".ex"}, 8'(endX), 8'(mex));
      chk({tag, ".ey"}, 8'(endY), 8'(mey));
    end
  endtask

  task automatic do_reset(input string tag);
    Reset = 1;
    #1;
    mx = 4; my = 6; msel = 0;
    msx = 0; msy = 0; mex = 0; mey = 0;
    exp_start = 0;
    check_idle(tag);
    chk({tag, ".ex0"}, 8'(endX), 8'd0);
    chk({tag, ".ey0"}, 8'(endY), 8'd0);
    tick;
    Reset = 0;
  endtask

  task automatic press(input bit u, input bit d, input bit l,
                       input bit r, input bit s, input bit c,
                       input string tag);
    logic [3:0] sq;
    bit own;
    sq = board[mx][my];
    own = (sq != 4'd0) && (sq[3] == turn);
    exp_start = 0;
    if (c) begin
      msel = 0;
    end else if (s) begin
      if (!msel) begin
        if (own) begin
          msel = 1; msx = mx; msy = my;
        end
      end else if (mx == msx && my == msy) begin
        msel = 0;
      end else if (own) begin
        msx = mx; msy = my;
      end else begin
        mex = mx; mey = my; exp_start = 1;
      end
    end else begin
      mx = (mx + int'(r) - int'(l) + 8) % 8;
      my = (my + int'(d) - int'(u) + 8) % 8;
    end
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    btn_select = s; btn_cancel = c;
    tick;
    clr_btn;
    check_idle(tag);
  endtask

  // Called in the START cycle; walks the five cycles up to the result.
  task automatic run_move(input bit toggle, input bit junk,
                          input string tag);
    for (int k = 1; k <= 5; k++) begin
      if (junk && k == 2) begin
        btn_right = 1; btn_select = 1;
      end
      tick;
      clr_btn;
      if (toggle && k == 3) turn = ~turn;
      chk({tag, ".start"}, 8'(START), 8'd0);
      chk({tag, ".ok"}, 8'(move_ok), 8'(k == 5 && toggle));
      chk({tag, ".bad"}, 8'(move_bad), 8'(k == 5 && !toggle));
      chk({tag, ".sel"}, 8'(src_selected), 8'(k < 5));
      chk({tag, ".curx"}, 8'(cursorX), 8'(mx));
      chk({tag, ".ex"}, 8'(endX), 8'(mex));
      chk({tag, ".sx"}, 8'(startX), 8'(msx));
    end
    msel = 0;
    exp_start = 0;
    tick;
    check_idle({tag, ".after"});
  endtask

  initial begin
    clr_btn;
    turn = 0;
    board = '0;
    do_reset("rst0");

    // Cursor wrap and cancelling pulses.
    for (int i = 0; i < 5; i++) press(0, 0, 0, 1, 0, 0, "right");
    chk("wrapx", 8'(cursorX), 8'd1);
    for (int i = 0; i < 7; i++) press(0, 1, 0, 0, 0, 0, "down");
    chk("wrapy", 8'(cursorY), 8'd5);
    press(0, 0, 1, 1, 0, 0, "lr_cancel");
    press(1, 1, 0, 1, 0, 0, "ud_cancel_x");

    // Legal move: white pawn (4,6) -> (4,4), engine flips turn.
    do_reset("rst1");
    board[4][6] = 4'b0001;
    press(0, 0, 0, 0, 1, 0, "src");
    press(1, 0, 0, 0, 0, 0, "up");
    press(1, 0, 0, 0, 0, 0, "up");
    press(0, 0, 0, 0, 1, 0, "confirm");
    chk("legal.sx", 8'(startX), 8'd4);
    chk("legal.sy", 8'(startY), 8'd6);
    chk("legal.ey", 8'(endY), 8'd4);
    run_move(1, 0, "legal");

    // Rejected move, with buttons pressed during the wait.
    turn = 0;
    press(0, 1, 0, 0, 0, 0, "down");
    press(0, 1, 0, 0, 0, 0, "down");
    press(0, 0, 0, 0, 1, 0, "src2");
    press(1, 0, 0, 0, 0, 0, "up");
    press(1, 0, 0, 0, 0, 0, "up");
    press(0, 0, 0, 0, 1, 0, "confirm2");
    run_move(0, 1, "reject");

    // Source filtering.
    board[3][6] = 4'b1001;
    board[5][6] = 4'b0010;
    press(0, 1, 0, 0, 0, 0, "down");
    press(0, 1, 0, 0, 0, 0, "down");
    press(0, 0, 1, 0, 0, 0, "left");
    press(0, 0, 0, 0, 1, 0, "sel_black");
    press(0, 0, 1, 0, 0, 0, "left");
    press(0, 0, 0, 0, 1, 0, "sel_empty");
    press(0, 0, 0, 1, 0, 0, "right");
    press(0, 0, 0, 1, 0, 0, "right");
    press(0, 0, 0, 0, 1, 0, "sel_white");
    chk("filt.sel", 8'(src_selected), 8'd1);
    press(0, 0, 0, 1, 0, 0, "right");
    press(0, 0, 0, 0, 1, 0, "reselect");
    chk("filt.sx", 8'(startX), 8'd5);
    press(0, 0, 0, 0, 1, 0, "deselect");
    chk("filt.desel", 8'(src_selected), 8'd0);

    // Cancel wins over select.
    press(0, 0, 0, 0, 1, 0, "src3");
    press(0, 0, 0, 0, 0, 1, "cancel");
    press(0, 0, 0, 0, 1, 0, "src4");
    press(0, 1, 0, 1, 1, 1, "cancel_sel");
    chk("prio.sel", 8'(src_selected), 8'd0);

    // Reset two cycles after START.
    press(0, 0, 0, 0, 1, 0, "src5");
    press(1, 0, 0, 0, 0, 0, "up");
    press(0, 0, 0, 0, 1, 0, "confirm3");
    tick;
    tick;
    do_reset("rst_mid");
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("post_rst.ok", 8'(move_ok), 8'd0);
      chk("post_rst.bad", 8'(move_bad), 8'd0);
      chk("post_rst.start", 8'(START), 8'd0);
    end
    check_idle("post_rst");

    // Random presses on a random board.
    turn = 0;
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        board[x][y] = ($urandom % 2 == 0) ? 4'd0
                      : 4'($urandom_range(1, 15));
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom % 10;
      if (r < 6)
        press(1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 0, 0, "rnd_dir");
      else if (r < 8)
        press(0, 0, 0, 0, 1, 0, "rnd_sel");
      else if (r == 8)
        press(0, 0, 0, 0, 0, 1, "rnd_can");
      else
        press(0, 0, 0, 0, 1, 1, "rnd_both");
      if (exp_start)
        run_move(1'($urandom), 1'($urandom), "rnd_move");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
